// File: rtl/cm_merge_arbiter.sv
// cm_merge_arbiter
// Round-robin arbiter merging two clocked four-phase Send/Ack requesters onto
// one downstream Send/Ack stage. The granted requester's data is registered
// onto Data_out, Send_out is driven downstream, and the downstream Ack is
// returned only to the granted requester.
//
// Parameters:
//   DW          data width of each channel
//   SYNC_STAGES flops on each Send_in*/Ack_in sync chain (0 = sample directly)
//   CNT_W       width of the completed-transfer counter
//
// Ports:
//   clk, MR            clock; synchronous active-high master reset
//   en                 grant enable; low blocks new grants only
//   Send_in0/Data_in0  requester 0 send and data;  Ack_out0 ack to requester 0
//   Send_in1/Data_in1  requester 1 send and data;  Ack_out1 ack to requester 1
//   Send_out/Data_out  send and registered data to the downstream stage
//   Ack_in             ack from the downstream stage
//   grant              index of the current or last granted requester
//   busy               high while the FSM is outside IDLE
//   cp                 one-cycle pulse per downstream acceptance
//   xfer_cnt           completed transfers, wrapping
module cm_merge_arbiter #(
  parameter int unsigned DW          = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             MR,
  input  logic             en,
  input  logic             Send_in0,
  input  logic [DW-1:0]    Data_in0,
  output logic             Ack_out0,
  input  logic             Send_in1,
  input  logic [DW-1:0]    Data_in1,
  output logic             Ack_out1,
  output logic             Send_out,
  output logic [DW-1:0]    Data_out,
  input  logic             Ack_in,
  output logic             grant,
  output logic             busy,
  output logic             cp,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACK
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  // Synchronized views of Send_in0, Send_in1, Ack_in; all FSM decisions use these.
  logic w_s0;
  logic w_s1;
  logic w_a;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_s0 = Send_in0;
      assign w_s1 = Send_in1;
      assign w_a  = Ack_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync_s0;
      logic [SYNC_STAGES-1:0] r_sync_s1;
      logic [SYNC_STAGES-1:0] r_sync_a;
      // Shift views one bit wider than the chain so a single-stage chain needs
      // no special case: the lower SYNC_STAGES bits are the next chain value.
      logic [SYNC_STAGES:0]   w_sh_s0;
      logic [SYNC_STAGES:0]   w_sh_s1;
      logic [SYNC_STAGES:0]   w_sh_a;

      assign w_sh_s0 = {r_sync_s0, Send_in0};
      assign w_sh_s1 = {r_sync_s1, Send_in1};
      assign w_sh_a  = {r_sync_a,  Ack_in};

      always_ff @(posedge clk) begin
        if (MR) begin
          r_sync_s0 <= '0;
          r_sync_s1 <= '0;
          r_sync_a  <= '0;
        end else begin
          r_sync_s0 <= w_sh_s0[SYNC_STAGES-1:0];
          r_sync_s1 <= w_sh_s1[SYNC_STAGES-1:0];
          r_sync_a  <= w_sh_a[SYNC_STAGES-1:0];
        end
      end

      assign w_s0 = r_sync_s0[SYNC_STAGES-1];
      assign w_s1 = r_sync_s1[SYNC_STAGES-1];
      assign w_a  = r_sync_a[SYNC_STAGES-1];
    end
  endgenerate

  logic             r_send;
  logic             r_ack0;
  logic             r_ack1;
  logic [DW-1:0]    r_data;
  logic             r_grant;
  logic             r_busy;
  logic             r_cp;
  logic [CNT_W-1:0] r_cnt;

  logic             w_send_nx;
  logic             w_ack0_nx;
  logic             w_ack1_nx;
  logic [DW-1:0]    w_data_nx;
  logic             w_grant_nx;
  logic             w_cp_nx;
  logic [CNT_W-1:0] w_cnt_nx;

  // Winner in IDLE: a lone requester wins; on a tie the port not granted last wins.
  logic w_sel;
  // Synchronized send of the currently granted port.
  logic w_s_g;

  assign w_sel = (w_s0 && w_s1) ? ~r_grant : w_s1;
  assign w_s_g = r_grant ? w_s1 : w_s0;

  always_comb begin
    w_state_nx = r_state;
    w_send_nx  = r_send;
    w_ack0_nx  = r_ack0;
    w_ack1_nx  = r_ack1;
    w_data_nx  = r_data;
    w_grant_nx = r_grant;
    w_cp_nx    = 1'b0;
    w_cnt_nx   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (en && (w_s0 || w_s1)) begin
          w_grant_nx = w_sel;
          w_data_nx  = w_sel ? Data_in1 : Data_in0;
          w_send_nx  = 1'b1;
          w_state_nx = ST_REQ;
        end
      end
      ST_REQ: begin
        if (w_a) begin
          // Send drops on the same edge the ack is raised, so Send_out and
          // Ack_out are never high together.
          w_send_nx  = 1'b0;
          if (r_grant) begin
            w_ack1_nx = 1'b1;
          end else begin
            w_ack0_nx = 1'b1;
          end
          w_cp_nx    = 1'b1;
          w_cnt_nx   = r_cnt + 1'b1;
          w_state_nx = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!w_s_g && !w_a) begin
          w_ack0_nx  = 1'b0;
          w_ack1_nx  = 1'b0;
          w_state_nx = ST_IDLE;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (MR) begin
      r_state <= ST_IDLE;
      r_send  <= 1'b0;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_data  <= '0;
      r_grant <= 1'b1;
      r_busy  <= 1'b0;
      r_cp    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_send  <= w_send_nx;
      r_ack0  <= w_ack0_nx;
      r_ack1  <= w_ack1_nx;
      r_data  <= w_data_nx;
      r_grant <= w_grant_nx;
      r_busy  <= (w_state_nx != ST_IDLE);
      r_cp    <= w_cp_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  assign Send_out = r_send;
  assign Ack_out0 = r_ack0;
  assign Ack_out1 = r_ack1;
  assign Data_out = r_data;
  assign grant    = r_grant;
  assign busy     = r_busy;
  assign cp       = r_cp;
  assign xfer_cnt = r_cnt;

endmodule

// File: tb/tb_cm_merge_arbiter.sv
module tb_cm_merge_arbiter;

  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: two-stage synchronizers, 4-bit counter.
  logic          MR, en;
  logic          Send_in0, Send_in1, Ack_in;
  logic [DW-1:0] Data_in0, Data_in1;
  logic          Ack_out0, Ack_out1, Send_out, grant, busy, cp;
  logic [DW-1:0] Data_out;
  logic [3:0]    xfer_cnt;

  // Second DUT: no synchronizers.
  logic          b_s0, b_s1, b_ack_in;
  logic [DW-1:0] b_d0, b_d1;
  logic          b_ack0, b_ack1, b_send_out, b_grant, b_busy, b_cp;
  logic [DW-1:0] b_data_out;
  logic [3:0]    b_cnt;

  cm_merge_arbiter #(.DW(DW), .SYNC_STAGES(2), .CNT_W(4)) u_dut (
    .clk(clk), .MR(MR), .en(en),
    .Send_in0(Send_in0), .Data_in0(Data_in0), .Ack_out0(Ack_out0),
    .Send_in1(Send_in1), .Data_in1(Data_in1), .Ack_out1(Ack_out1),
    .Send_out(Send_out), .Data_out(Data_out), .Ack_in(Ack_in),
    .grant(grant), .busy(busy), .cp(cp), .xfer_cnt(xfer_cnt)
  );

  cm_merge_arbiter #(.DW(DW), .SYNC_STAGES(0), .CNT_W(4)) u_dut0 (
    .clk(clk), .MR(MR), .en(en),
    .Send_in0(b_s0), .Data_in0(b_d0), .Ack_out0(b_ack0),
    .Send_in1(b_s1), .Data_in1(b_d1), .Ack_out1(b_ack1),
    .Send_out(b_send_out), .Data_out(b_data_out), .Ack_in(b_ack_in),
    .grant(b_grant), .busy(b_busy), .cp(b_cp), .xfer_cnt(b_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Exclusivity and cp-width monitor.
  logic mon_en  = 1'b0;
  logic cp_prev = 1'b0;
  int   cp_seen = 0;
  int   cp_wide = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      n_checks++;
      if ((Ack_out0 && Ack_out1) || (Send_out && (Ack_out0 || Ack_out1))) begin
        n_errors++;
        $display("FAIL exclusive: send=%0b ack0=%0b ack1=%0b at %0t", Send_out, Ack_out0, Ack_out1, $time);
      end
      if (cp) cp_seen++;
      if (cp && cp_prev) cp_wide++;
      cp_prev = cp;
    end
  end

  typedef struct {
    logic          mr, en, s0;
    logic [DW-1:0] d0;
    logic          s1;
    logic [DW-1:0] d1;
    logic          ack;
    logic          e_send, e_ack0, e_ack1;
    logic [DW-1:0] e_data;
    logic          e_grant, e_busy, e_cp;
    logic [3:0]    e_cnt;
  } vec_t;

  vec_t tbl [12];

  task automatic wait_send(input logic v, input string nm);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (Send_out == v) break;
    end
    chk(nm, Send_out, v);
  endtask

  task automatic wait_ack(input logic g, input logic v, input string nm);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ((g ? Ack_out1 : Ack_out0) == v) break;
    end
    chk(nm, g ? Ack_out1 : Ack_out0, v);
  endtask

  // One full four-phase transfer seen from the downstream side; the granted
  // requester drops its send after its ack and optionally re-raises it.
  task automatic do_xfer(input logic g, input logic [DW-1:0] d, input logic rearm);
    wait_send(1'b1, "xfer_send_rise");
    chk("xfer_grant", grant, g);
    chk("xfer_data", Data_out, d);
    chk("xfer_other_ack", g ? Ack_out0 : Ack_out1, 1'b0);
    Ack_in = 1'b1;
    wait_ack(g, 1'b1, "xfer_ack_rise");
    chk("xfer_send_fall", Send_out, 1'b0);
    exp_cnt++;
    chk("xfer_cnt", xfer_cnt, exp_cnt % 16);
    if (g) Send_in1 = 1'b0; else Send_in0 = 1'b0;
    Ack_in = 1'b0;
    wait_ack(g, 1'b0, "xfer_ack_fall");
    chk("xfer_idle", busy, 1'b0);
    if (rearm) begin
      if (g) Send_in1 = 1'b1; else Send_in0 = 1'b1;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    MR = 1'b1;
    repeat (n) @(negedge clk);
    MR = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cp_base;
    int wide_base;

    MR = 1'b1; en = 1'b1;
    Send_in0 = 1'b0; Send_in1 = 1'b0; Ack_in = 1'b0;
    Data_in0 = '0; Data_in1 = '0;
    b_s0 = 1'b0; b_s1 = 1'b0; b_ack_in = 1'b0; b_d0 = '0; b_d1 = '0;

    //              mr    en    s0    d0     s1    d1     ack   send  a0    a1    data   gnt   busy  cp    cnt
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 4'd0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 4'd0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 4'd0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 4'd1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 4'd1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 4'd1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 4'd1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 4'd1};

    // Reset and a single request on port 0, cycle by cycle.
    for (int r = 0; r < 12; r++) begin
      @(negedge clk);
      MR = tbl[r].mr; en = tbl[r].en;
      Send_in0 = tbl[r].s0; Data_in0 = tbl[r].d0;
      Send_in1 = tbl[r].s1; Data_in1 = tbl[r].d1;
      Ack_in = tbl[r].ack;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_send", r), Send_out, tbl[r].e_send);
      chk($sformatf("tbl%0d_ack0", r), Ack_out0, tbl[r].e_ack0);
      chk($sformatf("tbl%0d_ack1", r), Ack_out1, tbl[r].e_ack1);
      chk($sformatf("tbl%0d_data", r), Data_out, tbl[r].e_data);
      chk($sformatf("tbl%0d_grant", r), grant, tbl[r].e_grant);
      chk($sformatf("tbl%0d_busy", r), busy, tbl[r].e_busy);
      chk($sformatf("tbl%0d_cp", r), cp, tbl[r].e_cp);
      chk($sformatf("tbl%0d_cnt", r), xfer_cnt, tbl[r].e_cnt);
    end
    exp_cnt = 1;
    mon_en = 1'b1;

    // Zero-stage synchronizer instance: one-edge latency each way.
    @(negedge clk);
    b_s0 = 1'b1; b_d0 = 8'h3C;
    @(posedge clk); #1;
    chk("nosync_send", b_send_out, 1'b1);
    chk("nosync_data", b_data_out, 8'h3C);
    chk("nosync_grant", b_grant, 1'b0);
    @(negedge clk);
    b_ack_in = 1'b1;
    @(posedge clk); #1;
    chk("nosync_ack0", b_ack0, 1'b1);
    chk("nosync_send_fall", b_send_out, 1'b0);
    chk("nosync_cp", b_cp, 1'b1);
    chk("nosync_cnt", b_cnt, 4'd1);
    @(negedge clk);
    b_s0 = 1'b0; b_ack_in = 1'b0;
    @(posedge clk); #1;
    chk("nosync_ack0_fall", b_ack0, 1'b0);
    chk("nosync_busy", b_busy, 1'b0);

    // Simultaneous requests: round-robin 0,1,0,1 starting with port 0.
    do_reset(2);
    @(negedge clk);
    Data_in0 = 8'h11; Data_in1 = 8'h22;
    Send_in0 = 1'b1; Send_in1 = 1'b1;
    do_xfer(1'b0, 8'h11, 1'b1);
    do_xfer(1'b1, 8'h22, 1'b1);
    do_xfer(1'b0, 8'h11, 1'b1);
    do_xfer(1'b1, 8'h22, 1'b0);
    do_xfer(1'b0, 8'h11, 1'b0);

    // Gating: en low holds off a pending request; dropping en in REQ is harmless.
    @(negedge clk);
    en = 1'b0; Data_in1 = 8'h5A; Send_in1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("gate_hold%0d", i), Send_out, 1'b0);
    end
    en = 1'b1;
    @(posedge clk); #1;
    chk("gate_release_send", Send_out, 1'b1);
    chk("gate_release_grant", grant, 1'b1);
    @(negedge clk);
    en = 1'b0;
    do_xfer(1'b1, 8'h5A, 1'b0);
    en = 1'b1;

    // Master reset in the middle of REQ.
    @(negedge clk);
    Data_in0 = 8'h77; Send_in0 = 1'b1;
    wait_send(1'b1, "mr_req_send");
    chk("mr_req_busy", busy, 1'b1);
    @(negedge clk);
    MR = 1'b1; Send_in0 = 1'b0;
    @(posedge clk); #1;
    chk("mr_send", Send_out, 1'b0);
    chk("mr_ack0", Ack_out0, 1'b0);
    chk("mr_ack1", Ack_out1, 1'b0);
    chk("mr_cp", cp, 1'b0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_data", Data_out, 8'h00);
    chk("mr_cnt", xfer_cnt, 4'd0);
    chk("mr_grant", grant, 1'b1);
    repeat (3) @(negedge clk);
    MR = 1'b0;
    exp_cnt = 0;
    repeat (4) @(negedge clk);
    chk("mr_after_busy", busy, 1'b0);
    chk("mr_after_send", Send_out, 1'b0);

    // Counter wrap: 17 transfers on a 4-bit counter.
    cp_base = cp_seen;
    wide_base = cp_wide;
    for (int i = 0; i < 17; i++) begin
      Data_in0 = 8'(i + 8'h40);
      Send_in0 = 1'b1;
      do_xfer(1'b0, 8'(i + 8'h40), 1'b0);
    end
    @(negedge clk);
    chk("wrap_cnt", xfer_cnt, 4'd1);
    chk("wrap_cp_count", cp_seen - cp_base, 17);
    chk("wrap_cp_width", cp_wide - wide_base, 0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cm_merge_arbiter.md
Name: cm_merge_arbiter

Overview:
- Clocked round-robin arbiter that shares one downstream Send/Ack pipeline stage between two upstream requesters, using a four-phase Send/Ack handshake.
- Captures the granted requester's data and drives the downstream Send.
- Returns Ack to the granted requester only.
- Sits at the boundary where two clocked producers merge into the self-timed C-element pipeline; optional input synchronizers absorb Send_in/Ack_in asynchrony.

Parameters:
- DW, 32, data width of each channel.
- SYNC_STAGES, 2, flops on each Send_in*/Ack_in sync chain; 0 means sample directly.
- CNT_W, 16, width of the completed-transfer counter.

Ports:
- clk  input  1  clock.
- MR  input  1  master reset; synchronous, active-high.
- en  input  1  grant enable (gating); low blocks new grants only.
- Send_in0  input  1  requester 0 send (four-phase).
- Data_in0  input  DW  requester 0 data; stable while Send_in0 high.
- Ack_out0  output  1  ack to requester 0.
- Send_in1  input  1  requester 1 send.
- Data_in1  input  DW  requester 1 data.
- Ack_out1  output  1  ack to requester 1.
- Send_out  output  1  send to downstream stage.
- Data_out  output  DW  registered data to downstream.
- Ack_in  input  1  ack from downstream.
- grant  output  1  index of current or last granted requester.
- busy  output  1  high when the FSM is not in IDLE.
- cp  output  1  one-cycle pulse per downstream acceptance.
- xfer_cnt  output  CNT_W  completed transfers, wraps.

Behaviour:
- Reset (MR high at a clk edge):
  - State goes to IDLE; sync chains clear to 0.
  - Ack_out0, Ack_out1, Send_out, cp, busy are 0; Data_out and xfer_cnt are 0.
  - grant = 1, so requester 0 wins the first simultaneous request.
  - MR mid-transaction aborts it; upstream and downstream stages share MR.
- Sync: S0, S1, A denote Send_in0, Send_in1, Ack_in after SYNC_STAGES flops. All FSM decisions use S0, S1, A only.
- IDLE:
  - Grant is taken when en = 1 and (S0 or S1).
  - Port selection: if only one port requests, it wins. If both request, the winner is ~grant (round-robin).
  - On grant: grant <= winner, Data_out <= Data_in[winner], Send_out <= 1, go to REQ.
  - en = 0 leaves the FSM in IDLE; requests stay pending.
- REQ: wait for A = 1. Then:
  - Send_out <= 0.
  - Ack_out[grant] <= 1.
  - cp = 1 for exactly that cycle.
  - xfer_cnt += 1, wrapping at 2^CNT_W.
  - Go to ACK.
- ACK: wait for S[grant] = 0 and A = 0. Then Ack_out[grant] <= 0 and go to IDLE.
  - A new grant is possible on the next cycle; the earliest re-grant is the cycle after IDLE is entered.
- en falling during REQ or ACK has no effect; the transaction completes.
- Non-granted port: its Send stays pending and its Ack_out stays 0 throughout.
- busy = (state != IDLE), registered with the state.
- Data_out and grant hold their values after the transaction until the next grant.
- Latency:
  - Send_out rises SYNC_STAGES+1 edges after the first edge sampling Send_in high, given IDLE and en = 1.
  - Ack_out rises SYNC_STAGES+1 edges after Ack_in is first sampled high.
- Protocol violations (e.g. Send_in dropped before Ack_out) are not detected; behaviour is undefined except that MR recovers.
- Ack_out0 and Ack_out1 are never high simultaneously. Send_out and any Ack_out are never high simultaneously.

Test Plan:
- Reset: assert MR 3 cycles mid-REQ -> all outputs 0 (grant = 1) on the first edge with MR high; FSM returns to IDLE.
- Single request (DW = 8, SYNC_STAGES = 2): Send_in0 = 1 with Data_in0 = 0xA5 -> Send_out = 1 and Data_out = 0xA5 three edges later; grant = 0. Then Ack_in = 1 -> Ack_out0 = 1, cp pulses once, xfer_cnt = 1. Then drop Send_in0 and Ack_in -> Ack_out0 = 0, busy = 0.
- Simultaneous requests: Send_in0 and Send_in1 rise together (0x11, 0x22) -> first grant to port 0 (0x11), then port 1 (0x22); Ack_out1 stays 0 during port 0's transfer. Hold both high for 4 transfers -> grant sequence 0, 1, 0, 1.
- Gating: en = 0 with Send_in1 = 1 for 10 cycles -> Send_out stays 0. en = 1 -> Send_out rises on the next edge. en dropped during REQ -> transfer completes normally.
- Counter wrap (CNT_W = 4): 17 back-to-back transfers -> xfer_cnt reads 1; cp seen 17 times, each exactly 1 cycle wide.
- SYNC_STAGES = 0: Send_in0 high -> Send_out high after 1 edge; Ack_in high -> Ack_out0 high after 1 edge.
